// File: rtl/sa_drain_ctrl.sv
// Result drain controller: captures the full systolic-array result matrix and streams it out
// element by element on a valid/yumi port, then pulses a one-cycle array clear.
// Optional build macro SA_DRAIN_COLMAJOR_EN selects column-major drain order (default row-major).
module sa_drain_ctrl #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic                                             en_i,
    input  logic                                             flush_i,
    input  logic [width_p*array_width_p*array_height_p-1:0]  z_i,
    input  logic [array_width_p*array_height_p-1:0]          z_valid_i,
    output logic [array_width_p*array_height_p-1:0]          z_yumi_o,
    output logic                                             clear_o,
    output logic                                             valid_o,
    input  logic                                             yumi_i,
    output logic [width_p-1:0]                               data_o,
    output logic [((array_width_p*array_height_p) > 1 ? $clog2(array_width_p*array_height_p) : 1)-1:0] idx_o,
    output logic                                             last_o,
    output logic                                             busy_o
);

    localparam int N  = array_width_p * array_height_p;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0]    IDLE_S  = 3'b001;
    localparam logic [2:0]    DRAIN_S = 3'b010;
    localparam logic [2:0]    CLEAR_S = 3'b100;
    localparam logic [CW-1:0] LAST_C  = CW'(N - 1);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [width_p*N-1:0] buf_q, buf_d;
    logic [width_p-1:0]   data_q, data_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 clear_q, clear_d;
    logic                 capture_s;

    // Map the drain counter to the array element index k it presents.
    function automatic logic [CW-1:0] order_f(input logic [CW-1:0] c);
`ifdef SA_DRAIN_COLMAJOR_EN
        int k;
        k = (int'(c) % array_height_p) * array_width_p + (int'(c) / array_height_p);
        return CW'(k);
`else
        return c;
`endif
    endfunction

    assign capture_s = en_i & (&z_valid_i) & ~flush_i & (state_q == IDLE_S);
    assign z_yumi_o  = {N{capture_s}};

    // Next-state logic for the FSM, drain counter and capture buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (en_i) begin
            case (state_q)
                IDLE_S: begin
                    if (flush_i) begin
                        state_d = CLEAR_S;
                    end else if (capture_s) begin
                        state_d = DRAIN_S;
                        cnt_d   = {CW{1'b0}};
                        buf_d   = z_i;
                    end else begin
                        state_d = IDLE_S;
                    end
                end
                DRAIN_S: begin
                    if (yumi_i && (cnt_q != LAST_C)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // A coincident yumi still completes its element before the flush.
                    if (flush_i || (yumi_i && (cnt_q == LAST_C))) begin
                        state_d = CLEAR_S;
                    end else begin
                        state_d = DRAIN_S;
                    end
                end
                CLEAR_S: begin
                    state_d = IDLE_S;
                end
                default: begin
                    state_d = IDLE_S;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output registers are computed from next state so outputs come straight off flops.
    always_comb begin
        valid_d = (state_d == DRAIN_S);
        busy_d  = (state_d != IDLE_S);
        clear_d = (state_d == CLEAR_S);
        last_d  = 1'b0;
        idx_d   = {CW{1'b0}};
        data_d  = {width_p{1'b0}};
        if (valid_d) begin
            last_d = (cnt_d == LAST_C);
            idx_d  = order_f(cnt_d);
            data_d = buf_d[int'(idx_d)*width_p +: width_p];
        end else begin
            last_d = 1'b0;
            idx_d  = {CW{1'b0}};
            data_d = {width_p{1'b0}};
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE_S;
            cnt_q   <= {CW{1'b0}};
            buf_q   <= {(width_p*N){1'b0}};
            data_q  <= {width_p{1'b0}};
            idx_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            clear_q <= clear_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign clear_o = clear_q;

endmodule

// File: tb/tb_sa_drain_ctrl.sv
// Self-checking bench for sa_drain_ctrl (2x2, 32-bit): table of z_yumi vectors plus
// scoreboarded drain sequences covering backpressure, enable, partial valid, flush and reset.
module tb_sa_drain_ctrl;

    localparam int W  = 32;
    localparam int AW = 2;
    localparam int AH = 2;
    localparam int N  = AW * AH;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           en_i = 1'b1;
    logic           flush_i = 1'b0;
    logic [W*N-1:0] z_i = '0;
    logic [N-1:0]   z_valid_i = '0;
    logic [N-1:0]   z_yumi_o;
    logic           clear_o, valid_o, yumi_i, last_o, busy_o;
    logic [W-1:0]   data_o;
    logic [1:0]     idx_o;

    int checks = 0;
    int fails  = 0;

    typedef struct { logic [W-1:0] data; logic [1:0] idx; logic last; } exp_t;
    exp_t q[$];

    typedef struct { logic [N-1:0] zv; logic en; logic fl; logic [N-1:0] exp_yumi; } vec_t;
    vec_t vecs[7];

    logic         pend_r = 1'b0;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_idx;

    initial yumi_i = 1'b0;

    sa_drain_ctrl #(.width_p(W), .array_width_p(AW), .array_height_p(AH)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
        .z_i(z_i), .z_valid_i(z_valid_i), .z_yumi_o(z_yumi_o), .clear_o(clear_o),
        .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o), .idx_o(idx_o),
        .last_o(last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int ord(input int c);
`ifdef SA_DRAIN_COLMAJOR_EN
        return (c % AH) * AW + c / AH;
`else
        return c;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: transfers, data stability under backpressure, flush/reset discards.
    always @(negedge clk) begin
        exp_t e;
        if (reset_i) begin
            q.delete();
            pend_r = 1'b0;
        end else begin
            if (pend_r && valid_o) begin
                chk("hold_data", 64'(data_o), 64'(prev_data));
                chk("hold_idx", 64'(idx_o), 64'(prev_idx));
            end
            if (en_i && valid_o && yumi_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_xfer", 64'(data_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("xfer_data", 64'(data_o), 64'(e.data));
                    chk("xfer_idx", 64'(idx_o), 64'(e.idx));
                    chk("xfer_last", 64'(last_o), 64'(e.last));
                end
            end
            if (en_i && flush_i && valid_o) q.delete();
            pend_r    = valid_o && !(en_i && yumi_i) && !(en_i && flush_i);
            prev_data = data_o;
            prev_idx  = idx_o;
        end
    end

    task automatic capture(input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
        exp_t e;
        int   k;
        z_i       = {e3, e2, e1, e0};
        z_valid_i = 4'hF;
        #1;
        chk("cap_z_yumi", 64'(z_yumi_o), 64'hF);
        for (int c = 0; c < N; c++) begin
            k      = ord(c);
            e.data = z_i[k*W +: W];
            e.idx  = 2'(k);
            e.last = (c == N - 1);
            q.push_back(e);
        end
        tick();
        z_valid_i = 4'h0;
        chk("cap_valid_next", 64'(valid_o), 64'h1);
        chk("cap_idx0", 64'(idx_o), 64'(ord(0)));
        chk("cap_z_yumi_drain", 64'(z_yumi_o), 64'h0);
    endtask

    // mode 0: yumi held high; mode 1: yumi 1,0,0 pattern with en dropped mid-drain.
    task automatic drain(input int mode, output int cyc);
        cyc = 0;
        while (!clear_o && cyc < 40) begin
            if (mode == 0) begin
                yumi_i = 1'b1;
                en_i   = 1'b1;
            end else begin
                yumi_i = (cyc % 3 == 0);
                en_i   = !(cyc >= 4 && cyc < 8);
            end
            tick();
            cyc++;
        end
        yumi_i = 1'b0;
        en_i   = 1'b1;
        chk("clear_reached", 64'(clear_o), 64'h1);
        chk("scoreboard_empty", 64'(q.size()), 64'h0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{4'hF, 1'b1, 1'b0, 4'hF};
        vecs[1] = '{4'h7, 1'b1, 1'b0, 4'h0};
        vecs[2] = '{4'hF, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{4'hF, 1'b1, 1'b1, 4'h0};
        vecs[4] = '{4'hE, 1'b1, 1'b0, 4'h0};
        vecs[5] = '{4'h0, 1'b1, 1'b0, 4'h0};
        vecs[6] = '{4'hB, 1'b1, 1'b1, 4'h0};

        tick();
        tick();
        // Combinational z_yumi table exercised while reset holds the FSM in IDLE.
        for (int i = 0; i < 7; i++) begin
            z_valid_i = vecs[i].zv;
            en_i      = vecs[i].en;
            flush_i   = vecs[i].fl;
            #2;
            chk($sformatf("yumi_vec%0d", i), 64'(z_yumi_o), 64'(vecs[i].exp_yumi));
        end
        z_valid_i = 4'h0;
        en_i      = 1'b1;
        flush_i   = 1'b0;
        tick();
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_last", 64'(last_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_clear", 64'(clear_o), 64'h0);
        chk("rst_data", 64'(data_o), 64'h0);
        chk("rst_idx", 64'(idx_o), 64'h0);
        reset_i = 1'b0;
        tick();

        // Back-to-back drain: N transfer cycles, then a single-cycle clear.
        capture(32'd11, 32'd12, 32'd21, 32'd22);
        drain(0, cyc);
        chk("drain_cycles", 64'(cyc), 64'(N));
        tick();
        chk("clear_one_cycle", 64'(clear_o), 64'h0);
        chk("idle_not_busy", 64'(busy_o), 64'h0);

        // Backpressure with enable drop, then enable low holds CLEAR.
        capture(32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004);
        drain(1, cyc);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_held_en0", 64'(clear_o), 64'h1);
            chk("busy_held_en0", 64'(busy_o), 64'h1);
        end
        en_i = 1'b1;
        tick();
        chk("clear_release", 64'(clear_o), 64'h0);

        // Partial valid never captures.
        z_i = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 5; i++) begin
            z_valid_i = 4'b0111;
            #1;
            chk("partial_z_yumi", 64'(z_yumi_o), 64'h0);
            tick();
            chk("partial_busy", 64'(busy_o), 64'h0);
        end
        capture(32'd1, 32'd2, 32'd3, 32'd4);
        drain(0, cyc);
        tick();

        // Flush after the second element is accepted.
        capture(32'd11, 32'd12, 32'd21, 32'd22);
        yumi_i = 1'b1;
        tick();
        tick();
        yumi_i  = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_valid_low", 64'(valid_o), 64'h0);
        chk("flush_clear", 64'(clear_o), 64'h1);
        tick();
        chk("flush_clear_done", 64'(clear_o), 64'h0);
        chk("flush_idle", 64'(busy_o), 64'h0);
        chk("flush_discard", 64'(q.size()), 64'h0);

        // Flush coinciding with yumi: that element still counts.
        capture(32'd31, 32'd32, 32'd41, 32'd42);
        yumi_i  = 1'b1;
        flush_i = 1'b1;
        tick();
        yumi_i  = 1'b0;
        flush_i = 1'b0;
        chk("flush_yumi_clear", 64'(clear_o), 64'h1);
        chk("flush_yumi_valid", 64'(valid_o), 64'h0);
        tick();

        // Flush in IDLE goes straight to CLEAR without capturing.
        z_valid_i = 4'hF;
        flush_i   = 1'b1;
        #1;
        chk("idle_flush_z_yumi", 64'(z_yumi_o), 64'h0);
        tick();
        z_valid_i = 4'h0;
        flush_i   = 1'b0;
        chk("idle_flush_clear", 64'(clear_o), 64'h1);
        chk("idle_flush_valid", 64'(valid_o), 64'h0);
        tick();
        chk("idle_flush_done", 64'(clear_o), 64'h0);

        // Reset mid-drain, then a fresh matrix drains from k=0.
        capture(32'd11, 32'd12, 32'd21, 32'd22);
        yumi_i = 1'b1;
        tick();
        yumi_i  = 1'b0;
        reset_i = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(valid_o), 64'h0);
        chk("mid_rst_clear", 64'(clear_o), 64'h0);
        chk("mid_rst_busy", 64'(busy_o), 64'h0);
        chk("mid_rst_last", 64'(last_o), 64'h0);
        chk("mid_rst_data", 64'(data_o), 64'h0);
        chk("mid_rst_idx", 64'(idx_o), 64'h0);
        reset_i = 1'b0;
        tick();
        capture(32'd5, 32'd6, 32'd7, 32'd8);
        drain(0, cyc);
        chk("post_rst_cycles", 64'(cyc), 64'(N));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
